// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : Pipeline MEM stage. Issues one data-memory transaction per
//                aligned load/store, stalls the front of the pipeline while
//                the memory has not acknowledged, formats store lanes,
//                extends load data and registers the MEM/WB controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low

    input  logic        me_RegWrite,
    input  logic        me_MemWrite,
    input  logic [1:0]  me_WDsel,
    input  logic [1:0]  me_GPRSel,
    input  logic [2:0]  me_DMType,
    input  logic [4:0]  me_rd,
    input  logic [31:0] me_PC,
    input  logic [31:0] me_aluout,
    input  logic [31:0] me_RD2,

    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,

    output logic        mem_stall,

    output logic        wb_RegWrite,
    output logic [1:0]  wb_WDsel,
    output logic [1:0]  wb_GPRSel,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_PC,
    output logic [31:0] wb_aluout,
    output logic [31:0] wb_memdata,
    output logic        wb_misalign
);

    localparam logic [1:0] c_WDSEL_LOAD = 2'b01;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_access;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_signed;
    logic        w_misalign;
    logic        w_go;
    logic        w_req;
    logic        w_stall;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_data;
    logic [7:0]  w_byte_lane;
    logic [15:0] w_half_lane;
    logic [31:0] w_load_ext;

    // Access classification; codes 101-111 fall through to word handling.
    always_comb begin
        w_is_load   = (me_WDsel == c_WDSEL_LOAD);
        w_is_store  = me_MemWrite;
        w_access    = w_is_load | w_is_store;
        w_is_byte   = (me_DMType == 3'b011) | (me_DMType == 3'b100);
        w_is_half   = (me_DMType == 3'b001) | (me_DMType == 3'b010);
        w_is_signed = (me_DMType == 3'b001) | (me_DMType == 3'b011);
        if (w_is_byte)
            w_misalign = 1'b0;
        else if (w_is_half)
            w_misalign = me_aluout[0];
        else
            w_misalign = (me_aluout[1:0] != 2'b00);
        w_go = w_access & ~w_misalign;
    end

    // Handshake state register; reset abandons any outstanding transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and request/stall decode; both forced low while in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        if (rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        w_req = 1'b1;
                        if (!dm_ack) begin
                            w_stall     = 1'b1;
                            w_state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    w_req = 1'b1;
                    if (dm_ack)
                        w_state_nxt = ST_IDLE;
                    else
                        w_stall = 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Store lane replication and byte enables for the addressed lanes.
    always_comb begin
        w_st_be   = 4'b1111;
        w_st_data = me_RD2;
        if (w_is_byte) begin
            w_st_be   = 4'b0001 << me_aluout[1:0];
            w_st_data = {4{me_RD2[7:0]}};
        end else if (w_is_half) begin
            w_st_be   = me_aluout[1] ? 4'b1100 : 4'b0011;
            w_st_data = {2{me_RD2[15:0]}};
        end
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        case (me_aluout[1:0])
            2'd0:    w_byte_lane = dm_rdata[7:0];
            2'd1:    w_byte_lane = dm_rdata[15:8];
            2'd2:    w_byte_lane = dm_rdata[23:16];
            default: w_byte_lane = dm_rdata[31:24];
        endcase
        w_half_lane = me_aluout[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        w_load_ext  = dm_rdata;
        if (w_is_byte)
            w_load_ext = w_is_signed ? {{24{w_byte_lane[7]}}, w_byte_lane}
                                     : {24'd0, w_byte_lane};
        else if (w_is_half)
            w_load_ext = w_is_signed ? {{16{w_half_lane[15]}}, w_half_lane}
                                     : {16'd0, w_half_lane};
    end

    assign dm_req    = w_req;
    assign dm_we     = w_req & w_is_store;
    assign dm_addr   = {me_aluout[31:2], 2'b00};
    assign dm_wdata  = w_st_data;
    assign dm_be     = w_req ? w_st_be : 4'b0000;
    assign mem_stall = w_stall;

    // MEM/WB register: bubble while stalled, capture otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_RegWrite <= 1'b0;
            wb_WDsel    <= 2'b00;
            wb_GPRSel   <= 2'b00;
            wb_rd       <= 5'd0;
            wb_PC       <= 32'd0;
            wb_aluout   <= 32'd0;
            wb_memdata  <= 32'd0;
            wb_misalign <= 1'b0;
        end else if (w_stall) begin
            wb_RegWrite <= 1'b0;
            wb_WDsel    <= 2'b00;
            wb_GPRSel   <= 2'b00;
            wb_rd       <= 5'd0;
            wb_PC       <= 32'd0;
            wb_aluout   <= 32'd0;
            wb_memdata  <= 32'd0;
            wb_misalign <= 1'b0;
        end else begin
            wb_RegWrite <= me_RegWrite & ~(w_access & w_misalign);
            wb_WDsel    <= me_WDsel;
            wb_GPRSel   <= me_GPRSel;
            wb_rd       <= me_rd;
            wb_PC       <= me_PC;
            wb_aluout   <= me_aluout;
            wb_memdata  <= (w_is_load & ~w_misalign) ? w_load_ext : 32'd0;
            wb_misalign <= w_access & w_misalign;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Self-checking bench for mem_access: directed scenarios plus
//                randomized loads/stores against an arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        me_RegWrite;
    logic        me_MemWrite;
    logic [1:0]  me_WDsel;
    logic [1:0]  me_GPRSel;
    logic [2:0]  me_DMType;
    logic [4:0]  me_rd;
    logic [31:0] me_PC;
    logic [31:0] me_aluout;
    logic [31:0] me_RD2;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_stall;
    logic        wb_RegWrite;
    logic [1:0]  wb_WDsel;
    logic [1:0]  wb_GPRSel;
    logic [4:0]  wb_rd;
    logic [31:0] wb_PC;
    logic [31:0] wb_aluout;
    logic [31:0] wb_memdata;
    logic        wb_misalign;

    int total = 0;
    int bad   = 0;

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .me_RegWrite (me_RegWrite),
        .me_MemWrite (me_MemWrite),
        .me_WDsel    (me_WDsel),
        .me_GPRSel   (me_GPRSel),
        .me_DMType   (me_DMType),
        .me_rd       (me_rd),
        .me_PC       (me_PC),
        .me_aluout   (me_aluout),
        .me_RD2      (me_RD2),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_be       (dm_be),
        .dm_rdata    (dm_rdata),
        .dm_ack      (dm_ack),
        .mem_stall   (mem_stall),
        .wb_RegWrite (wb_RegWrite),
        .wb_WDsel    (wb_WDsel),
        .wb_GPRSel   (wb_GPRSel),
        .wb_rd       (wb_rd),
        .wb_PC       (wb_PC),
        .wb_aluout   (wb_aluout),
        .wb_memdata  (wb_memdata),
        .wb_misalign (wb_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes for a data type code.
    function automatic int size_of(input logic [2:0] t);
        case (t)
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 4;
        endcase
    endfunction

    // Reference load result: shift the addressed bytes down, mask, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int          sz  = size_of(t);
        bit          sgn = (t == 3'd1) || (t == 3'd3);
        logic [31:0] v   = rdata >> (8 * (addr % 4));
        if (sz == 1) begin
            v = v % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (sz == 2) begin
            v = v % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] t, input logic [31:0] d);
        int sz = size_of(t);
        if (sz == 1) return (d % 256) * 32'h0101_0101;
        if (sz == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] t, input logic [31:0] addr);
        int sz = size_of(t);
        return ((1 << sz) - 1) << (addr % 4);
    endfunction

    task automatic check_bubble(input string tag);
        chk({tag, "_bub_rw"},  wb_RegWrite, 0);
        chk({tag, "_bub_mis"}, wb_misalign, 0);
        chk({tag, "_bub_alu"}, wb_aluout, 0);
        chk({tag, "_bub_pc"},  wb_PC, 0);
        chk({tag, "_bub_md"},  wb_memdata, 0);
        chk({tag, "_bub_rd"},  wb_rd, 0);
    endtask

    // Present one instruction, acknowledge after 'waits' cycles, check each cycle.
    task automatic run_instr(input string tag, input logic rw, input logic mw,
                             input logic [1:0] wds, input logic [2:0] dt,
                             input logic [31:0] addr, input logic [31:0] rd2,
                             input logic [31:0] rdata, input int waits_in);
        logic [1:0]  gs  = 2'($urandom);
        logic [4:0]  rdn = 5'($urandom);
        logic [31:0] pc  = $urandom;
        int          sz  = size_of(dt);
        bit          ld  = (wds == 2'b01);
        bit          st  = mw;
        bit          acc = ld || st;
        bit          mis = acc && ((addr % sz) != 0);
        bit          go  = acc && !mis;
        int          waits = go ? waits_in : 0;
        @(negedge clk);
        me_RegWrite = rw;  me_MemWrite = mw;  me_WDsel = wds;  me_GPRSel = gs;
        me_DMType   = dt;  me_rd = rdn;       me_PC = pc;      me_aluout = addr;
        me_RD2      = rd2;
        dm_ack      = go ? (waits == 0) : 1'($urandom);
        dm_rdata    = (waits == 0) ? rdata : $urandom;
        for (int c = 0; c <= waits; c++) begin
            if (c > 0) begin
                @(negedge clk);
                dm_ack   = (c == waits);
                dm_rdata = (c == waits) ? rdata : $urandom;
            end
            #1;
            chk({tag, "_req"},   dm_req, go);
            chk({tag, "_stall"}, mem_stall, go && (c < waits));
            if (go) begin
                chk({tag, "_addr"}, dm_addr, addr - (addr % 4));
                chk({tag, "_we"},   dm_we, st);
                if (st) begin
                    chk({tag, "_be"},    dm_be, model_be(dt, addr));
                    chk({tag, "_wdata"}, dm_wdata, model_wdata(dt, rd2));
                end
            end
            @(posedge clk);
            #1;
            if (go && (c < waits)) begin
                check_bubble(tag);
            end else begin
                chk({tag, "_wb_rw"},  wb_RegWrite, rw && !mis);
                chk({tag, "_wb_mis"}, wb_misalign, mis);
                chk({tag, "_wb_wds"}, wb_WDsel, wds);
                chk({tag, "_wb_gs"},  wb_GPRSel, gs);
                chk({tag, "_wb_rd"},  wb_rd, rdn);
                chk({tag, "_wb_pc"},  wb_PC, pc);
                chk({tag, "_wb_alu"}, wb_aluout, addr);
                chk({tag, "_wb_md"},  wb_memdata, (ld && !mis) ? model_load(dt, addr, rdata) : 0);
            end
        end
    endtask

    task automatic idle_inputs();
        me_RegWrite = 0; me_MemWrite = 0; me_WDsel = 2'b00; me_GPRSel = 0;
        me_DMType = 0;   me_rd = 0;       me_PC = 0;        me_aluout = 0;
        me_RD2 = 0;
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        dm_ack = 1'b0;
        dm_rdata = 0;
        // An access presented during reset must not raise a request.
        me_WDsel = 2'b01;
        dm_ack   = 1'b1;
        #12;
        chk("rst_req",   dm_req, 0);
        chk("rst_stall", mem_stall, 0);
        check_bubble("rst");
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;

        // Zero-wait signed byte load from the top lane.
        run_instr("lb0", 1, 0, 2'b01, 3'd3, 32'h103, 0, 32'h80AA55CC, 0);
        chk("lb0_const_md", wb_memdata, 32'hFFFFFF80);
        chk("lb0_const_rw", wb_RegWrite, 1);

        // Halfword store held for three cycles.
        run_instr("sh3", 0, 1, 2'b00, 3'd1, 32'h202, 32'h1234ABCD, 0, 3);
        chk("sh3_const_alu", wb_aluout, 32'h202);

        // Unsigned half load, upper half.
        run_instr("lhu", 1, 0, 2'b01, 3'd2, 32'h002, 0, 32'h8001FFFF, 0);
        chk("lhu_const_md", wb_memdata, 32'h00008001);

        // Misaligned word load.
        run_instr("lwmis", 1, 0, 2'b01, 3'd0, 32'h101, 0, 32'h11223344, 0);
        chk("lwmis_const_mis", wb_misalign, 1);
        chk("lwmis_const_rw",  wb_RegWrite, 0);

        // Back-to-back zero-wait word store then word load.
        run_instr("sw_b2b", 0, 1, 2'b00, 3'd0, 32'h40, 32'hDEADBEEF, 0, 0);
        run_instr("lw_b2b", 1, 0, 2'b01, 3'd0, 32'h44, 0, 32'hCAFEF00D, 0);
        chk("lw_b2b_const_md", wb_memdata, 32'hCAFEF00D);

        // Reset asserted while waiting for an acknowledge.
        @(negedge clk);
        me_RegWrite = 1; me_WDsel = 2'b01; me_DMType = 3'd0; me_aluout = 32'h300;
        dm_ack = 0;
        @(negedge clk);
        #1;
        chk("wait_req", dm_req, 1);
        chk("wait_stall", mem_stall, 1);
        rst = 1'b0;
        #1;
        chk("rstwait_req",   dm_req, 0);
        chk("rstwait_stall", mem_stall, 0);
        check_bubble("rstwait");
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dm_ack = 1'($urandom);
            #1;
            chk("post_rst_req", dm_req, 0);
            chk("post_rst_stall", mem_stall, 0);
            @(negedge clk);
        end

        // Reset clears captured MEM/WB state without waiting for a clock.
        run_instr("lb_pre", 1, 0, 2'b01, 3'd4, 32'h1, 0, 32'h0000F100, 0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        check_bubble("async_rst");
        @(negedge clk);
        rst = 1'b1;

        // Randomized mix of idle cycles, loads and stores of every type.
        for (int i = 0; i < 120; i++) begin
            int          kind = $urandom_range(0, 2);
            logic [2:0]  dt   = 3'($urandom_range(0, 7));
            logic [31:0] a    = $urandom;
            logic [1:0]  wds;
            logic        rw;
            if ($urandom_range(0, 1) == 1) a = a - (a % size_of(dt));
            case (kind)
                0:       begin wds = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11; rw = 1'($urandom); end
                1:       begin wds = 2'b01; rw = 1'($urandom); end
                default: begin wds = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00; rw = 0; end
            endcase
            run_instr("rnd", rw, kind == 2, wds, dt, a, $urandom, $urandom,
                      $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
